// File: rtl/move_scheduler.sv
// Round-based movement sequencer: one shared clamp-and-collision checker serves the four characters in turn.
// Optional rotating priority is enabled by defining MOVE_SCHED_ROUND_ROBIN_EN; otherwise priority is fixed 0..3.
module move_scheduler #(
  parameter int XLIMIT   = 95,
  parameter int YLIMIT   = 63,
  parameter int CHAR_W   = 20,
  parameter int CHAR_H   = 20,
  parameter int STEP_DIV = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick,
  input  logic [3:0]  req_valid,
  input  logic [7:0]  req_dir,
  output logic [27:0] pos_x,
  output logic [23:0] pos_y,
  output logic [7:0]  dir,
  output logic [3:0]  blocked,
  output logic        busy,
  output logic        round_done
);

  localparam int CNT_W = (STEP_DIV < 1) ? 1 : $clog2(STEP_DIV + 1);
  localparam logic [6:0] X_MAX = 7'(XLIMIT - CHAR_W);
  localparam logic [5:0] Y_MAX = 6'(YLIMIT - CHAR_H);
  localparam logic [7:0] W8 = 8'(CHAR_W);
  localparam logic [7:0] H8 = 8'(CHAR_H);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SLOT, S_CHK0, S_CHK1, S_CHK2, S_COMMIT, S_DONE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       slot_idx_reg;
  logic [1:0]       slot_cnt_reg;
  logic [3:0]       req_valid_reg;
  logic [7:0]       req_dir_reg;
  logic [6:0]       cand_x_reg;
  logic [5:0]       cand_y_reg;
  logic             hit_reg;
  logic [6:0]       pos_x_reg [4];
  logic [5:0]       pos_y_reg [4];
  logic [7:0]       dir_reg;
  logic [3:0]       blocked_reg;
  logic             busy_reg;
  logic             round_done_reg;
  logic [1:0]       ptr;

`ifdef MOVE_SCHED_ROUND_ROBIN_EN
  logic [1:0] ptr_reg;
  assign ptr = ptr_reg;
`else
  assign ptr = 2'd0;
`endif

  logic [1:0] cur_dir;
  logic [6:0] cur_x, next_x;
  logic [5:0] cur_y, next_y;
  logic [1:0] chk_k, oth_idx;
  logic [7:0] ax, ay, bx, by;
  logic       overlap;
  logic       last_slot;

  always_comb begin
    cur_dir = req_dir_reg[{slot_idx_reg, 1'b0} +: 2];
    cur_x   = pos_x_reg[slot_idx_reg];
    cur_y   = pos_y_reg[slot_idx_reg];
    next_x  = cur_x;
    next_y  = cur_y;
    case (cur_dir)
      2'b00: next_y = (cur_y == 6'd0) ? 6'd0 : cur_y - 6'd1;
      2'b01: next_y = (cur_y >= Y_MAX) ? Y_MAX : cur_y + 6'd1;
      2'b10: next_x = (cur_x == 7'd0) ? 7'd0 : cur_x - 7'd1;
      default: next_x = (cur_x >= X_MAX) ? X_MAX : cur_x + 7'd1;
    endcase
    last_slot = (slot_cnt_reg == 2'd3);
  end

  // The three other characters are visited in ascending index order by skipping the mover.
  always_comb begin
    case (state_reg)
      S_CHK0:  chk_k = 2'd0;
      S_CHK1:  chk_k = 2'd1;
      default: chk_k = 2'd2;
    endcase
    oth_idx = (chk_k < slot_idx_reg) ? chk_k : chk_k + 2'd1;
    ax = {1'b0, cand_x_reg};
    bx = {1'b0, pos_x_reg[oth_idx]};
    ay = {2'b00, cand_y_reg};
    by = {2'b00, pos_y_reg[oth_idx]};
    overlap = (ax < bx + W8) && (ax + W8 > bx) && (ay < by + H8) && (ay + H8 > by);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      slot_idx_reg   <= 2'd0;
      slot_cnt_reg   <= 2'd0;
      req_valid_reg  <= 4'd0;
      req_dir_reg    <= 8'd0;
      cand_x_reg     <= 7'd0;
      cand_y_reg     <= 6'd0;
      hit_reg        <= 1'b0;
      pos_x_reg[0]   <= 7'd10;
      pos_y_reg[0]   <= 6'd10;
      pos_x_reg[1]   <= 7'd60;
      pos_y_reg[1]   <= 6'd10;
      pos_x_reg[2]   <= 7'd10;
      pos_y_reg[2]   <= 6'd40;
      pos_x_reg[3]   <= 7'd60;
      pos_y_reg[3]   <= 6'd40;
      dir_reg        <= 8'd0;
      blocked_reg    <= 4'd0;
      busy_reg       <= 1'b0;
      round_done_reg <= 1'b0;
`ifdef MOVE_SCHED_ROUND_ROBIN_EN
      ptr_reg        <= 2'd0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          round_done_reg <= 1'b0;
          if (tick) begin
            if (cnt_reg == '0) begin
              cnt_reg   <= CNT_W'(STEP_DIV);
              busy_reg  <= 1'b1;
              state_reg <= S_START;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
        end
        S_START: begin
          req_valid_reg <= req_valid;
          req_dir_reg   <= req_dir;
          blocked_reg   <= 4'd0;
          slot_idx_reg  <= ptr;
          slot_cnt_reg  <= 2'd0;
          state_reg     <= S_SLOT;
        end
        S_SLOT: begin
          if (req_valid_reg[slot_idx_reg] && (next_x != cur_x || next_y != cur_y)) begin
            dir_reg[{slot_idx_reg, 1'b0} +: 2] <= cur_dir;
            cand_x_reg <= next_x;
            cand_y_reg <= next_y;
            hit_reg    <= 1'b0;
            state_reg  <= S_CHK0;
          end else begin
            if (req_valid_reg[slot_idx_reg])
              dir_reg[{slot_idx_reg, 1'b0} +: 2] <= cur_dir;
            if (last_slot) begin
              busy_reg       <= 1'b0;
              round_done_reg <= 1'b1;
              state_reg      <= S_DONE;
            end else begin
              slot_idx_reg <= slot_idx_reg + 2'd1;
              slot_cnt_reg <= slot_cnt_reg + 2'd1;
            end
          end
        end
        S_CHK0: begin
          hit_reg   <= hit_reg | overlap;
          state_reg <= S_CHK1;
        end
        S_CHK1: begin
          hit_reg   <= hit_reg | overlap;
          state_reg <= S_CHK2;
        end
        S_CHK2: begin
          hit_reg   <= hit_reg | overlap;
          state_reg <= S_COMMIT;
        end
        S_COMMIT: begin
          if (hit_reg) begin
            blocked_reg[slot_idx_reg] <= 1'b1;
          end else begin
            pos_x_reg[slot_idx_reg] <= cand_x_reg;
            pos_y_reg[slot_idx_reg] <= cand_y_reg;
          end
          if (last_slot) begin
            busy_reg       <= 1'b0;
            round_done_reg <= 1'b1;
            state_reg      <= S_DONE;
          end else begin
            slot_idx_reg <= slot_idx_reg + 2'd1;
            slot_cnt_reg <= slot_cnt_reg + 2'd1;
            state_reg    <= S_SLOT;
          end
        end
        default: begin
          round_done_reg <= 1'b0;
`ifdef MOVE_SCHED_ROUND_ROBIN_EN
          ptr_reg        <= ptr_reg + 2'd1;
`endif
          state_reg      <= S_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pack
      assign pos_x[7*gi +: 7] = pos_x_reg[gi];
      assign pos_y[6*gi +: 6] = pos_y_reg[gi];
    end
  endgenerate

  assign dir        = dir_reg;
  assign blocked    = blocked_reg;
  assign busy       = busy_reg;
  assign round_done = round_done_reg;

endmodule
